// File: rtl/local_injector.sv
// Injection stage in front of a router local port: turns a (dest, len) request
// plus payload words into header/body/tail flits, stalling on local_full_i.
module local_injector #(
    parameter int ROUTER_ID = 7,
    parameter int MAX_LEN   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [3:0]  req_dest_i,
    input  logic [3:0]  req_len_i,
    output logic        req_ready_o,
    input  logic        word_valid_i,
    input  logic [13:0] word_data_i,
    output logic        word_ready_o,
    input  logic        local_full_i,
    output logic [16:0] local_data_o,
    output logic        busy_o,
    output logic        pkt_sent_o
);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    localparam logic [3:0] SRC_ID = 4'(ROUTER_ID);
    localparam logic [3:0] MAX_L  = 4'(MAX_LEN);

    state_t      state_q, state_d;
    logic [3:0]  dest_q, dest_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  rem_q, rem_d;
    logic [16:0] data_q, data_d;
    logic        sent_q, sent_d;
    logic        consume;
    logic [13:0] hdr_payload;

    assign hdr_payload = {dest_q, SRC_ID, len_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        rem_d       = rem_q;
        data_d      = '0;
        sent_d      = 1'b0;
        req_ready_o = 1'b0;
        consume     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    dest_d  = req_dest_i;
                    len_d   = (req_len_i > MAX_L) ? MAX_L : req_len_i;
                    rem_d   = len_d;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (!local_full_i) begin
                    if (len_q == 4'd0) begin
                        data_d  = {1'b1, 2'b11, hdr_payload};
                        sent_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        data_d  = {1'b1, 2'b10, hdr_payload};
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                consume = word_valid_i & ~local_full_i;
                if (consume) begin
                    rem_d = (rem_q != 4'd0) ? rem_q - 4'd1 : 4'd0;
                    // rem_q==1 means this word is the tail
                    if (rem_q == 4'd1) begin
                        data_d  = {1'b1, 2'b01, word_data_i};
                        sent_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        data_d  = {1'b1, 2'b00, word_data_i};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
        end
    end

    assign word_ready_o = consume;
    assign local_data_o = data_q;
    assign pkt_sent_o   = sent_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_local_injector.sv
// Bench for local_injector: directed plan scenarios with exact timing, then
// random packets checked against a per-packet expected-flit queue.
module tb_local_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [3:0]  req_dest_i;
    logic [3:0]  req_len_i;
    logic        req_ready_o;
    logic        word_valid_i;
    logic [13:0] word_data_i;
    logic        word_ready_o;
    logic        local_full_i;
    logic [16:0] local_data_o;
    logic        busy_o;
    logic        pkt_sent_o;

    int          nvec = 0;
    int          nfail = 0;
    bit          mon_en = 1'b0;
    logic        prev_full = 1'b0;
    logic [17:0] expq[$];   // {pkt_sent expected, flit}

    local_injector #(.ROUTER_ID(7), .MAX_LEN(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_dest_i(req_dest_i), .req_len_i(req_len_i),
        .req_ready_o(req_ready_o),
        .word_valid_i(word_valid_i), .word_data_i(word_data_i), .word_ready_o(word_ready_o),
        .local_full_i(local_full_i), .local_data_o(local_data_o),
        .busy_o(busy_o), .pkt_sent_o(pkt_sent_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Every observed flit must be the next one the packet rules predict
    task automatic mon();
        logic [17:0] e;
        if (local_data_o[16] === 1'b1) begin
            chk("issue_while_full", {31'd0, prev_full}, 32'd0);
            if (expq.size() == 0) begin
                chk("extra_flit", {15'd0, local_data_o}, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("flit", {15'd0, local_data_o}, {15'd0, e[16:0]});
                chk("sent", {31'd0, pkt_sent_o}, {31'd0, e[17]});
            end
        end else begin
            chk("bubble", {15'd0, local_data_o}, 32'd0);
            chk("sent_bubble", {31'd0, pkt_sent_o}, 32'd0);
        end
    endtask

    task automatic tick();
        prev_full = local_full_i;
        @(posedge clk);
        #1;
        if (mon_en) mon();
    endtask

    task automatic send_rand(input int full_pct, input int gap_pct);
        logic [3:0]  d;
        logic [3:0]  l;
        logic [13:0] w[15];
        int          ll;
        int          i;
        int          cyc;
        d  = 4'($urandom);
        l  = 4'($urandom_range(0, 15));
        ll = int'(l);
        expq.push_back({(ll == 0), 1'b1, (ll == 0) ? 2'b11 : 2'b10, d, 4'd7, l, 2'b00});
        for (int k = 0; k < ll; k++) begin
            w[k] = 14'($urandom);
            expq.push_back({(k == ll - 1), 1'b1, (k == ll - 1) ? 2'b01 : 2'b00, w[k]});
        end
        req_valid_i  = 1'b1;
        req_dest_i   = d;
        req_len_i    = l;
        word_valid_i = 1'b0;
        local_full_i = ($urandom_range(0, 99) < full_pct);
        #1;
        chk("rand_req_ready", {31'd0, req_ready_o}, 32'd1);
        tick();
        i   = 0;
        cyc = 0;
        while (expq.size() != 0 && cyc < 300) begin
            local_full_i = ($urandom_range(0, 99) < full_pct);
            word_valid_i = (i < ll) && ($urandom_range(0, 99) >= gap_pct);
            word_data_i  = (i < ll) ? w[i] : 14'($urandom);
            // words still owed means the packet is in flight, so requests must be ignored
            req_valid_i  = (i < ll) && ($urandom_range(0, 9) == 0);
            req_dest_i   = 4'($urandom);
            req_len_i    = 4'($urandom);
            #1;
            chk("wr_legal", {31'd0, word_ready_o & ~(word_valid_i & ~local_full_i)}, 32'd0);
            if (word_ready_o) i++;
            tick();
            cyc++;
        end
        if (cyc >= 300) chk("timeout", cyc, 0);
        chk("words_used", i, ll);
        req_valid_i  = 1'b0;
        word_valid_i = 1'b0;
        local_full_i = 1'b0;
        expq.delete();
    endtask

    initial begin
        logic [13:0] wv[3];
        logic [16:0] fl[3];
        rst = 1'b1; req_valid_i = 1'b0; req_dest_i = '0; req_len_i = '0;
        word_valid_i = 1'b0; word_data_i = '0; local_full_i = 1'b0;

        // reset
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_data", {15'd0, local_data_o}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_word_ready", {31'd0, word_ready_o}, 32'd0);
        chk("rst_sent", {31'd0, pkt_sent_o}, 32'd0);

        // header-only packet
        req_valid_i = 1'b1; req_dest_i = 4'hB; req_len_i = 4'd0;
        tick();
        req_valid_i = 1'b0;
        chk("ho_busy", {31'd0, busy_o}, 32'd1);
        chk("ho_ready_head", {31'd0, req_ready_o}, 32'd0);
        chk("ho_data_acc", {15'd0, local_data_o}, 32'd0);
        tick();
        chk("ho_flit", {15'd0, local_data_o}, 32'h1EDC0);
        chk("ho_sent", {31'd0, pkt_sent_o}, 32'd1);
        tick();
        chk("ho_after", {15'd0, local_data_o}, 32'd0);
        chk("ho_sent_after", {31'd0, pkt_sent_o}, 32'd0);
        chk("ho_idle", {31'd0, busy_o}, 32'd0);

        // 3-body packet, no stalls
        wv = '{14'h0001, 14'h0002, 14'h0003};
        fl = '{17'h10001, 17'h10002, 17'h14003};
        req_valid_i = 1'b1; req_dest_i = 4'd3; req_len_i = 4'd3;
        tick();
        req_valid_i = 1'b0;
        tick();
        chk("p3_hdr", {15'd0, local_data_o}, 32'h18DCC);
        for (int k = 0; k < 3; k++) begin
            word_valid_i = 1'b1; word_data_i = wv[k];
            #1;
            chk("p3_wr", {31'd0, word_ready_o}, 32'd1);
            tick();
            chk("p3_flit", {15'd0, local_data_o}, {15'd0, fl[k]});
            chk("p3_sent", {31'd0, pkt_sent_o}, (k == 2) ? 32'd1 : 32'd0);
        end
        word_valid_i = 1'b0;
        tick();
        chk("p3_after", {15'd0, local_data_o}, 32'd0);
        chk("p3_idle", {31'd0, busy_o}, 32'd0);

        // same packet with 3-cycle back-pressure after the first body flit
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        chk("bp_hdr", {15'd0, local_data_o}, 32'h18DCC);
        word_valid_i = 1'b1; word_data_i = 14'h0001;
        tick();
        chk("bp_b1", {15'd0, local_data_o}, 32'h10001);
        local_full_i = 1'b1; word_data_i = 14'h0002;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_wr_stall", {31'd0, word_ready_o}, 32'd0);
            tick();
            chk("bp_stall_data", {15'd0, local_data_o}, 32'd0);
        end
        local_full_i = 1'b0;
        tick();
        chk("bp_b2", {15'd0, local_data_o}, 32'h10002);
        word_data_i = 14'h0003;
        tick();
        chk("bp_tail", {15'd0, local_data_o}, 32'h14003);
        chk("bp_sent", {31'd0, pkt_sent_o}, 32'd1);
        word_valid_i = 1'b0;
        tick();

        // word gap with a request pulsed during BODY
        req_valid_i = 1'b1; req_dest_i = 4'd5; req_len_i = 4'd2;
        tick();
        req_valid_i = 1'b0;
        tick();
        chk("gap_hdr", {15'd0, local_data_o}, 32'h195C8);
        word_valid_i = 1'b1; word_data_i = 14'h1234;
        tick();
        chk("gap_b1", {15'd0, local_data_o}, 32'h11234);
        word_valid_i = 1'b0;
        req_valid_i = 1'b1; req_dest_i = 4'hF; req_len_i = 4'd1;
        tick();
        chk("gap_bubble1", {15'd0, local_data_o}, 32'd0);
        req_valid_i = 1'b0;
        tick();
        chk("gap_bubble2", {15'd0, local_data_o}, 32'd0);
        word_valid_i = 1'b1; word_data_i = 14'h2ABC;
        tick();
        chk("gap_tail", {15'd0, local_data_o}, 32'h16ABC);
        chk("gap_sent", {31'd0, pkt_sent_o}, 32'd1);
        word_valid_i = 1'b0;
        tick();
        chk("gap_no_req_latched", {31'd0, busy_o}, 32'd0);
        tick();
        chk("gap_no_second_hdr", {15'd0, local_data_o}, 32'd0);

        // reset mid-BODY
        req_valid_i = 1'b1; req_dest_i = 4'd1; req_len_i = 4'd3;
        tick();
        req_valid_i = 1'b0;
        tick();
        word_valid_i = 1'b1; word_data_i = 14'h0AAA;
        tick();
        chk("mr_b1", {15'd0, local_data_o}, 32'h10AAA);
        rst = 1'b1; word_data_i = 14'h0BBB;
        tick();
        rst = 1'b0; word_valid_i = 1'b0;
        #1;
        chk("mr_data", {15'd0, local_data_o}, 32'd0);
        chk("mr_sent", {31'd0, pkt_sent_o}, 32'd0);
        chk("mr_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("mr_busy", {31'd0, busy_o}, 32'd0);
        tick();
        chk("mr_no_tail", {15'd0, local_data_o}, 32'd0);

        // randomized packets against the expected-flit queue
        mon_en = 1'b1;
        for (int p = 0; p < 40; p++) begin
            send_rand((p < 10) ? 0 : 30, (p < 10) ? 0 : 30);
            if ($urandom_range(0, 1) == 1) tick();
        end
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
